fib_sequencer: RTL and testbench

- Control FSM that sequences the shared 16x16 register file and the ALU to fill registers R0..Rn with a Fibonacci-style sequence.
- Drives the regfile's one-hot write enables and read selects, the ALU opcode and the immediate write-back path.
- Reports busy/done/overflow to the top level through a start/done handshake.
- Owns no data storage; all values live in the regfile.

---
 rtl/fib_sequencer.sv | 94 +++++++++
 tb/tb_fib_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/fib_sequencer.sv
// fib_sequencer: control FSM that fills regfile R0..Rn with a Fibonacci-style sequence through the ALU
module fib_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REGS = 16,
    parameter logic [3:0] ADD_OP = 4'b0101,
    parameter logic [DATA_WIDTH-1:0] SEED0 = DATA_WIDTH'(0),
    parameter logic [DATA_WIDTH-1:0] SEED1 = DATA_WIDTH'(1),
    localparam int IW = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [IW-1:0]         n_last,
    input  logic                  alu_carry,
    output logic [NUM_REGS-1:0]   reg_enable,
    output logic [IW-1:0]         rd_a_sel,
    output logic [IW-1:0]         rd_b_sel,
    output logic [3:0]            alu_op,
    output logic                  imm_en,
    output logic [DATA_WIDTH-1:0] imm,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);
    typedef enum logic [2:0] {IDLE, INIT0, INIT1, STEP, DONE} state_t;
    state_t state, state_nxt;
    logic [IW-1:0] idx, n;
    logic accept;
    assign accept = (state == IDLE || state == DONE) && start;
    // state register plus the run bookkeeping: latched length, write index, sticky carry
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx <= '0;
            n <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                n <= n_last;
                overflow <= 1'b0;
            end
            if (state == INIT1) idx <= IW'(2);
            if (state == STEP && alu_carry) overflow <= 1'b1;
            if (state == STEP && !alu_carry && idx != n) idx <= idx + IW'(1);
        end
    end
    // next state: seeds first, then add steps until idx reaches n or the ALU carries out
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? INIT0 : IDLE;
            INIT0:   state_nxt = (n == '0) ? DONE : INIT1;
            INIT1:   state_nxt = (n == IW'(1)) ? DONE : STEP;
            STEP:    state_nxt = (alu_carry || idx == n) ? DONE : STEP;
            DONE:    state_nxt = start ? INIT0 : DONE;
            default: state_nxt = IDLE;
        endcase
    end
    // Moore outputs decoded from state and idx only
    always_comb begin
        reg_enable = '0;
        rd_a_sel = '0;
        rd_b_sel = '0;
        alu_op = '0;
        imm_en = 1'b0;
        imm = '0;
        busy = 1'b0;
        done = 1'b0;
        case (state)
            INIT0: begin
                reg_enable = NUM_REGS'(1);
                imm_en = 1'b1;
                imm = SEED0;
                busy = 1'b1;
            end
            INIT1: begin
                reg_enable = NUM_REGS'(2);
                imm_en = 1'b1;
                imm = SEED1;
                busy = 1'b1;
            end
            STEP: begin
                reg_enable = NUM_REGS'(1) << idx;
                rd_a_sel = idx - IW'(1);
                rd_b_sel = idx - IW'(2);
                alu_op = ADD_OP;
                busy = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_fib_sequencer.sv
// tb_fib_sequencer: two sequencers (default and large seeds) driving behavioural regfile/ALU models, checked against a Fibonacci reference
module tb_fib_sequencer;
    localparam logic [3:0] ADD = 4'b0101;
    logic clk = 1'b0;
    logic reset, start_a, start_b, sel;
    logic [3:0] n_last;
    logic [15:0] en_a, en_b, imm_a, imm_b;
    logic [3:0] ra_a, rb_a, ra_b, rb_b, op_a, op_b;
    logic ie_a, ie_b, busy_a, busy_b, done_a, done_b, ov_a, ov_b, carry_a, carry_b;
    logic [16:0] sum_a, sum_b;
    logic [15:0] rf_a [16];
    logic [15:0] rf_b [16];
    logic [15:0] o_en, o_imm;
    logic [3:0] o_ra, o_rb, o_op;
    logic o_ie, o_busy, o_done, o_ov;
    int checks = 0, passed = 0, fails = 0;

    always #5 clk = ~clk;

    fib_sequencer dut_a (
        .clk(clk), .reset(reset), .start(start_a), .n_last(n_last), .alu_carry(carry_a),
        .reg_enable(en_a), .rd_a_sel(ra_a), .rd_b_sel(rb_a), .alu_op(op_a), .imm_en(ie_a),
        .imm(imm_a), .busy(busy_a), .done(done_a), .overflow(ov_a)
    );
    fib_sequencer #(.SEED0(16'd30000), .SEED1(16'd30000)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .n_last(n_last), .alu_carry(carry_b),
        .reg_enable(en_b), .rd_a_sel(ra_b), .rd_b_sel(rb_b), .alu_op(op_b), .imm_en(ie_b),
        .imm(imm_b), .busy(busy_b), .done(done_b), .overflow(ov_b)
    );

    assign sum_a = {1'b0, rf_a[ra_a]} + {1'b0, rf_a[rb_a]};
    assign sum_b = {1'b0, rf_b[ra_b]} + {1'b0, rf_b[rb_b]};
    assign carry_a = (op_a == ADD) && sum_a[16];
    assign carry_b = (op_b == ADD) && sum_b[16];

    always @(posedge clk) begin
        for (int i = 0; i < 16; i++) begin
            if (en_a[i]) rf_a[i] <= ie_a ? imm_a : sum_a[15:0];
            if (en_b[i]) rf_b[i] <= ie_b ? imm_b : sum_b[15:0];
        end
    end

    assign o_en = sel ? en_b : en_a;
    assign o_imm = sel ? imm_b : imm_a;
    assign o_ra = sel ? ra_b : ra_a;
    assign o_rb = sel ? rb_b : rb_a;
    assign o_op = sel ? op_b : op_a;
    assign o_ie = sel ? ie_b : ie_a;
    assign o_busy = sel ? busy_b : busy_a;
    assign o_done = sel ? done_b : done_a;
    assign o_ov = sel ? ov_b : ov_a;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk(tag, {o_en, o_ra, o_rb, o_op, o_ie, o_imm, o_busy, o_done, o_ov}, 64'd0);
    endtask

    function automatic logic [15:0] rf_rd(input bit b, input int i);
        return b ? rf_b[i] : rf_a[i];
    endfunction

    // one complete run: reference values from plain Fibonacci arithmetic, then cycle-by-cycle checks
    task automatic run(input bit b, input logic [3:0] nl, input logic [3:0] nl_after, input int poke);
        int s0, s1, k, sum;
        bit ovf;
        logic [15:0] v [16];
        logic [15:0] snap [16];
        s0 = b ? 30000 : 0;
        s1 = b ? 30000 : 1;
        ovf = 1'b0;
        v[0] = 16'(s0);
        k = 0;
        if (nl >= 1) begin
            v[1] = 16'(s1);
            k = 1;
        end
        for (int i = 2; i <= int'(nl) && !ovf; i++) begin
            sum = int'(v[i-1]) + int'(v[i-2]);
            v[i] = 16'(sum);
            k = i;
            ovf = sum > 65535;
        end
        for (int i = 0; i < 16; i++) snap[i] = rf_rd(b, i);
        sel = b;
        @(negedge clk);
        n_last = nl;
        if (b) start_b = 1'b1;
        else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        n_last = nl_after;
        chk("ov_cleared", o_ov, 0);
        for (int c = 1; c <= k + 1; c++) begin
            chk($sformatf("en_c%0d", c), o_en, 16'(1) << (c - 1));
            chk($sformatf("busy_c%0d", c), {o_busy, o_done}, 2'b10);
            chk($sformatf("op_c%0d", c), {o_op, o_ie}, c >= 3 ? {ADD, 1'b0} : {4'd0, 1'b1});
            if (c < 3) chk($sformatf("imm_c%0d", c), o_imm, c == 1 ? 16'(s0) : 16'(s1));
            else chk($sformatf("sel_c%0d", c), {o_ra, o_rb}, {4'(c - 2), 4'(c - 3)});
            if (c == poke) begin
                if (b) start_b = 1'b1;
                else start_a = 1'b1;
            end
            @(negedge clk);
            start_a = 1'b0;
            start_b = 1'b0;
        end
        chk("done_state", {o_busy, o_done, o_ov, o_en}, {1'b0, 1'b1, ovf, 16'd0});
        for (int i = 0; i < 16; i++)
            chk($sformatf("rf%0d_R%0d", b, i), rf_rd(b, i), i <= k ? v[i] : snap[i]);
    endtask

    initial begin
        logic [15:0] snap [16];
        reset = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        n_last = 4'd0;
        sel = 1'b0;
        repeat (2) @(negedge clk);
        start_a = 1'b1;
        start_b = 1'b1;
        @(negedge clk);
        chk_idle("reset_a");
        sel = 1'b1;
        chk_idle("reset_b");
        start_a = 1'b0;
        start_b = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk_idle("idle_b");
        sel = 1'b0;
        chk_idle("idle_a");
        run(0, 4'd15, 4'd3, 0);
        chk("R15_610", rf_a[15], 16'd610);
        chk("R10_55", rf_a[10], 16'd55);
        run(0, 4'd0, 4'd9, 0);
        run(0, 4'd1, 4'd0, 0);
        run(1, 4'd10, 4'd15, 0);
        chk("R2_60000", rf_b[2], 16'd60000);
        chk("R3_24464", rf_b[3], 16'd24464);
        chk("carry_ov", ov_b, 1'b1);
        run(1, 4'd2, 4'd7, 1);
        chk("ov_clear_new_run", ov_b, 1'b0);
        // abort a long run while STEP writes R6
        for (int i = 0; i < 16; i++) snap[i] = 16'(i * 1000 + 7);
        sel = 1'b0;
        @(negedge clk);
        n_last = 4'd15;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int i = 0; i < 16; i++) snap[i] = rf_a[i];
        repeat (6) @(negedge clk);
        chk("abort_idx6", {o_en, o_ra, o_rb}, {16'h0040, 4'd5, 4'd4});
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_idle("abort_idle");
        @(negedge clk);
        chk_idle("abort_stays_idle");
        chk("abort_R6", rf_a[6], 16'd8);
        for (int i = 7; i < 16; i++) chk($sformatf("abort_keep_R%0d", i), rf_a[i], snap[i]);
        run(0, 4'd15, 4'd15, 5);
        run(0, 4'd4, 4'd12, 3);
        for (int t = 0; t < 12; t++)
            run(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom), $urandom_range(0, 17));
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
